// File: rtl/lv2_rd_responder_lv1_lv2_pkg.sv
// Shared lv1-lv2 read bus definitions: responder states, default sizes, requester indices.
package pkg_lv1_lv2_bus;

    localparam int unsigned DEF_NUM_REQ  = 8;
    localparam int unsigned DEF_REQ_WID  = 3;
    localparam int unsigned DEF_ADDR_WID = 32;
    localparam int unsigned DEF_DATA_WID = 32;
    localparam int unsigned DEF_WAIT_TO  = 15;
    localparam int unsigned DEF_TO_WID   = 4;

    // Requester index = core*2 + (0 IL, 1 DL)
    localparam int unsigned REQ_C0_IL = 0;
    localparam int unsigned REQ_C0_DL = 1;
    localparam int unsigned REQ_C1_IL = 2;
    localparam int unsigned REQ_C1_DL = 3;
    localparam int unsigned REQ_C2_IL = 4;
    localparam int unsigned REQ_C2_DL = 5;
    localparam int unsigned REQ_C3_IL = 6;
    localparam int unsigned REQ_C3_DL = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        ARRAY = 2'd2,
        DRIVE = 2'd3
    } state_t;

endpackage

// File: rtl/lv2_rd_responder_lv1_lv2_if.sv
// lv1-lv2 read bus plus the L2 array port as seen by the responder (slave) and its environment (master).
interface lv2_rd_responder_lv1_lv2_if
    import pkg_lv1_lv2_bus::*;
#(
    parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
    parameter int unsigned REQ_WID  = DEF_REQ_WID,
    parameter int unsigned ADDR_WID = DEF_ADDR_WID,
    parameter int unsigned DATA_WID = DEF_DATA_WID
) ();

    logic [NUM_REQ-1:0]  bus_lv1_lv2_req;
    logic [NUM_REQ-1:0]  bus_lv1_lv2_gnt;
    logic                lv2_rd;
    logic [ADDR_WID-1:0] addr_bus_lv1_lv2;
    logic [DATA_WID-1:0] data_bus_lv1_lv2;
    logic                data_in_bus_lv1_lv2;
    logic                lv2_arr_rd;
    logic [ADDR_WID-1:0] lv2_arr_addr;
    logic [DATA_WID-1:0] lv2_arr_data;
    logic                lv2_arr_vld;
    logic [REQ_WID-1:0]  gnt_owner;
    logic                rd_timeout_err;

    modport slave (
        input  bus_lv1_lv2_req, lv2_rd, addr_bus_lv1_lv2, lv2_arr_data, lv2_arr_vld,
        output bus_lv1_lv2_gnt, data_bus_lv1_lv2, data_in_bus_lv1_lv2,
               lv2_arr_rd, lv2_arr_addr, gnt_owner, rd_timeout_err
    );

    modport master (
        output bus_lv1_lv2_req, lv2_rd, addr_bus_lv1_lv2, lv2_arr_data, lv2_arr_vld,
        input  bus_lv1_lv2_gnt, data_bus_lv1_lv2, data_in_bus_lv1_lv2,
               lv2_arr_rd, lv2_arr_addr, gnt_owner, rd_timeout_err
    );

endinterface

// File: rtl/lv2_rd_responder_lv1_lv2_rr_arbiter.sv
// Combinational round-robin pick: first set request scanning upward from ptr with wrap.
module rr_arbiter_lv1_lv2 #(
    parameter int unsigned NUM_REQ = 8,
    parameter int unsigned REQ_WID = 3
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [REQ_WID-1:0] ptr,
    output logic [REQ_WID-1:0] winner,
    output logic               any_req
);

    logic [REQ_WID-1:0] idx;

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = REQ_WID'((32'(ptr) + i) % NUM_REQ);
            if (!any_req && req[idx]) begin
                winner  = idx;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lv2_rd_responder_lv1_lv2.sv
// L2-side responder for the lv1-lv2 read bus: RR grant, one array read per grant, hold until release.
module lv2_rd_responder_lv1_lv2
    import pkg_lv1_lv2_bus::*;
#(
    parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
    parameter int unsigned REQ_WID  = DEF_REQ_WID,
    parameter int unsigned ADDR_WID = DEF_ADDR_WID,
    parameter int unsigned DATA_WID = DEF_DATA_WID,
    parameter int unsigned WAIT_TO  = DEF_WAIT_TO,
    parameter int unsigned TO_WID   = DEF_TO_WID
) (
    input logic                         clk,
    input logic                         rst,
    lv2_rd_responder_lv1_lv2_if.slave   bus
);

    state_t              state_q, state_d;
    logic [REQ_WID-1:0]  ptr_q, ptr_d;
    logic [TO_WID-1:0]   cnt_q, cnt_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [REQ_WID-1:0]  owner_q, owner_d;
    logic [DATA_WID-1:0] data_q, data_d;
    logic                strobe_q, strobe_d;
    logic                arr_rd_q, arr_rd_d;
    logic [ADDR_WID-1:0] arr_addr_q, arr_addr_d;
    logic                err_q, err_d;
    logic                abort_q, abort_d;

    logic [REQ_WID-1:0]  winner;
    logic                any_req;
    logic                owner_req;
    logic [REQ_WID-1:0]  ptr_after_owner;

    rr_arbiter_lv1_lv2 #(
        .NUM_REQ (NUM_REQ),
        .REQ_WID (REQ_WID)
    ) u_arb (
        .req     (bus.bus_lv1_lv2_req),
        .ptr     (ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    assign owner_req       = bus.bus_lv1_lv2_req[owner_q];
    assign ptr_after_owner = (owner_q == REQ_WID'(NUM_REQ - 1)) ? '0 : owner_q + REQ_WID'(1);

    // Next-state and registered-output decode
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        data_d     = data_q;
        strobe_d   = strobe_q;
        arr_rd_d   = arr_rd_q;
        arr_addr_d = arr_addr_q;
        err_d      = 1'b0;
        abort_d    = abort_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    gnt_d   = NUM_REQ'(1) << winner;
                    owner_d = winner;
                    cnt_d   = '0;
                    abort_d = 1'b0;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!owner_req) begin
                    gnt_d   = '0;
                    state_d = IDLE;
                end else if (bus.lv2_rd) begin
                    arr_addr_d = bus.addr_bus_lv1_lv2;
                    arr_rd_d   = 1'b1;
                    abort_d    = 1'b0;
                    state_d    = ARRAY;
                end else begin
                    cnt_d = cnt_q + TO_WID'(1);
                    if (cnt_d == TO_WID'(WAIT_TO)) begin
                        gnt_d   = '0;
                        err_d   = 1'b1;
                        ptr_d   = ptr_after_owner;
                        state_d = IDLE;
                    end
                end
            end
            ARRAY: begin
                // A requester that left mid-read still costs one array completion; the data is dropped
                if (bus.lv2_arr_vld) begin
                    arr_rd_d = 1'b0;
                    if (abort_q || !owner_req) begin
                        gnt_d   = '0;
                        ptr_d   = ptr_after_owner;
                        state_d = IDLE;
                    end else begin
                        data_d   = bus.lv2_arr_data;
                        strobe_d = 1'b1;
                        state_d  = DRIVE;
                    end
                end else if (!owner_req) begin
                    abort_d = 1'b1;
                end
            end
            DRIVE: begin
                if (!owner_req) begin
                    strobe_d = 1'b0;
                    gnt_d    = '0;
                    data_d   = '0;
                    ptr_d    = ptr_after_owner;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            cnt_q      <= '0;
            gnt_q      <= '0;
            owner_q    <= '0;
            data_q     <= '0;
            strobe_q   <= 1'b0;
            arr_rd_q   <= 1'b0;
            arr_addr_q <= '0;
            err_q      <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            data_q     <= data_d;
            strobe_q   <= strobe_d;
            arr_rd_q   <= arr_rd_d;
            arr_addr_q <= arr_addr_d;
            err_q      <= err_d;
            abort_q    <= abort_d;
        end
    end

    assign bus.bus_lv1_lv2_gnt     = gnt_q;
    assign bus.gnt_owner           = owner_q;
    assign bus.data_bus_lv1_lv2    = data_q;
    assign bus.data_in_bus_lv1_lv2 = strobe_q;
    assign bus.lv2_arr_rd          = arr_rd_q;
    assign bus.lv2_arr_addr        = arr_addr_q;
    assign bus.rd_timeout_err      = err_q;

endmodule

// File: tb/tb_lv2_rd_responder_lv1_lv2.sv
// Directed bench for the lv1-lv2 read responder; read data checked through an expected-data queue.
module tb_lv2_rd_responder_lv1_lv2;
    import pkg_lv1_lv2_bus::*;

    logic clk;
    logic rst;

    lv2_rd_responder_lv1_lv2_if bus ();

    lv2_rd_responder_lv1_lv2 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned   checks = 0;
    int unsigned   errors = 0;
    logic [31:0]   exp_q[$];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Array answers with data d; the expected value goes to the scoreboard unless the read is aborted
    task automatic array_resp(input int lat, input logic [31:0] d, input bit expect_data);
        repeat (lat) tick();
        bus.lv2_arr_data = d;
        bus.lv2_arr_vld  = 1'b1;
        if (expect_data) exp_q.push_back(d);
        tick();
        bus.lv2_arr_vld  = 1'b0;
    endtask

    task automatic wait_strobe(input string tag);
        logic [31:0] e;
        for (int i = 0; i < 10 && !bus.data_in_bus_lv1_lv2; i++) tick();
        chk({tag, "_strobe"}, 64'(bus.data_in_bus_lv1_lv2), 64'd1);
        chk({tag, "_sb_depth"}, 64'(exp_q.size()), 64'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, 64'(bus.data_bus_lv1_lv2), 64'(e));
        end
    endtask

    task automatic issue_rd(input logic [31:0] a);
        bus.lv2_rd           = 1'b1;
        bus.addr_bus_lv1_lv2 = a;
        tick();
        bus.lv2_rd           = 1'b0;
    endtask

    initial begin
        int unsigned o;
        int unsigned n;

        rst                  = 1'b1;
        bus.bus_lv1_lv2_req  = '0;
        bus.lv2_rd           = 1'b0;
        bus.addr_bus_lv1_lv2 = '0;
        bus.lv2_arr_data     = '0;
        bus.lv2_arr_vld      = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_gnt", 64'(bus.bus_lv1_lv2_gnt), 64'h0);
        chk("rst_strobe", 64'(bus.data_in_bus_lv1_lv2), 64'h0);
        chk("rst_data", 64'(bus.data_bus_lv1_lv2), 64'h0);
        chk("rst_arr_rd", 64'(bus.lv2_arr_rd), 64'h0);
        chk("rst_owner", 64'(bus.gnt_owner), 64'h0);

        // Single read from requester 0
        bus.bus_lv1_lv2_req = 8'h01;
        tick();
        chk("t1_gnt", 64'(bus.bus_lv1_lv2_gnt), 64'h01);
        chk("t1_owner", 64'(bus.gnt_owner), 64'(REQ_C0_IL));
        issue_rd(32'h0000_1040);
        chk("t1_arr_rd", 64'(bus.lv2_arr_rd), 64'h1);
        chk("t1_arr_addr", 64'(bus.lv2_arr_addr), 64'h1040);
        array_resp(2, 32'hDEAD_BEEF, 1'b1);
        chk("t1_arr_rd_off", 64'(bus.lv2_arr_rd), 64'h0);
        wait_strobe("t1");
        tick();
        chk("t1_hold_strobe", 64'(bus.data_in_bus_lv1_lv2), 64'h1);
        chk("t1_hold_data", 64'(bus.data_bus_lv1_lv2), 64'hDEAD_BEEF);
        bus.bus_lv1_lv2_req = 8'h00;
        tick();
        chk("t1_rel_gnt", 64'(bus.bus_lv1_lv2_gnt), 64'h0);
        chk("t1_rel_strobe", 64'(bus.data_in_bus_lv1_lv2), 64'h0);
        chk("t1_rel_data", 64'(bus.data_bus_lv1_lv2), 64'h0);

        // All requesters held; each completes immediately: order 0..7,0 with one idle cycle between
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.bus_lv1_lv2_req = 8'hFF;
        tick();
        for (int k = 0; k < 9; k++) begin
            o = k % 8;
            chk($sformatf("t2_gnt%0d", k), 64'(bus.bus_lv1_lv2_gnt), 64'(8'h01 << o));
            chk($sformatf("t2_owner%0d", k), 64'(bus.gnt_owner), 64'(o));
            issue_rd(32'(o) << 4);
            chk($sformatf("t2_addr%0d", k), 64'(bus.lv2_arr_addr), 64'(32'(o) << 4));
            array_resp(0, 32'hA500_0000 | 32'(k), 1'b1);
            wait_strobe($sformatf("t2_%0d", k));
            bus.bus_lv1_lv2_req[o] = 1'b0;
            tick();
            chk($sformatf("t2_turn%0d", k), 64'(bus.bus_lv1_lv2_gnt), 64'h0);
            bus.bus_lv1_lv2_req[o] = 1'b1;
            tick();
        end
        chk("t2_next", 64'(bus.bus_lv1_lv2_gnt), 64'h02);
        bus.bus_lv1_lv2_req = 8'h00;
        tick();
        chk("t2_drop", 64'(bus.bus_lv1_lv2_gnt), 64'h0);

        // Owner 5 completes, pointer moves to 6; {1,6} requesting wraps 6 then 1
        bus.bus_lv1_lv2_req = 8'h20;
        tick();
        chk("t3_gnt5", 64'(bus.bus_lv1_lv2_gnt), 64'h20);
        issue_rd(32'h0000_5000);
        array_resp(0, 32'h5555_0005, 1'b1);
        wait_strobe("t3_5");
        bus.bus_lv1_lv2_req = 8'h42;
        tick();
        chk("t3_turn", 64'(bus.bus_lv1_lv2_gnt), 64'h0);
        tick();
        chk("t3_gnt6", 64'(bus.bus_lv1_lv2_gnt), 64'h40);
        chk("t3_owner6", 64'(bus.gnt_owner), 64'(REQ_C3_IL));
        issue_rd(32'h0000_6000);
        array_resp(1, 32'h6666_0006, 1'b1);
        wait_strobe("t3_6");
        bus.bus_lv1_lv2_req = 8'h02;
        tick();
        tick();
        chk("t3_gnt1", 64'(bus.bus_lv1_lv2_gnt), 64'h02);
        bus.bus_lv1_lv2_req = 8'h00;
        tick();

        // Requester 3 never reads: revoke after WAIT_TO granted cycles, then 4 is next
        bus.bus_lv1_lv2_req = 8'h18;
        tick();
        chk("t4_gnt3", 64'(bus.bus_lv1_lv2_gnt), 64'h08);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.bus_lv1_lv2_gnt != 8'h08) break;
            n++;
            chk($sformatf("t4_no_err%0d", i), 64'(bus.rd_timeout_err), 64'h0);
        end
        chk("t4_len", 64'(n), 64'd15);
        chk("t4_err", 64'(bus.rd_timeout_err), 64'h1);
        chk("t4_revoked", 64'(bus.bus_lv1_lv2_gnt), 64'h0);
        tick();
        chk("t4_err_once", 64'(bus.rd_timeout_err), 64'h0);
        chk("t4_gnt4", 64'(bus.bus_lv1_lv2_gnt), 64'h10);
        chk("t4_owner4", 64'(bus.gnt_owner), 64'd4);
        bus.bus_lv1_lv2_req = 8'h00;
        tick();

        // Requester 2 leaves during ARRAY: no strobe, grant clears on vld, pointer to 3
        bus.bus_lv1_lv2_req = 8'h04;
        tick();
        chk("t5_gnt2", 64'(bus.bus_lv1_lv2_gnt), 64'h04);
        issue_rd(32'h0000_2200);
        bus.bus_lv1_lv2_req = 8'h00;
        tick();
        chk("t5_gnt_held", 64'(bus.bus_lv1_lv2_gnt), 64'h04);
        chk("t5_arr_rd_held", 64'(bus.lv2_arr_rd), 64'h1);
        array_resp(1, 32'hBAD0_0002, 1'b0);
        chk("t5_no_strobe", 64'(bus.data_in_bus_lv1_lv2), 64'h0);
        chk("t5_gnt_clr", 64'(bus.bus_lv1_lv2_gnt), 64'h0);
        chk("t5_arr_rd_clr", 64'(bus.lv2_arr_rd), 64'h0);
        chk("t5_data_clr", 64'(bus.data_bus_lv1_lv2), 64'h0);
        bus.bus_lv1_lv2_req = 8'h0C;
        tick();
        chk("t5_ptr3", 64'(bus.bus_lv1_lv2_gnt), 64'h08);

        // Reset while driving, with a stray array vld during and after reset
        issue_rd(32'h0000_3300);
        array_resp(0, 32'h3333_0003, 1'b1);
        wait_strobe("t6");
        rst             = 1'b1;
        bus.lv2_arr_vld = 1'b1;
        bus.lv2_arr_data = 32'hFFFF_FFFF;
        tick();
        rst = 1'b0;
        chk("t6_gnt", 64'(bus.bus_lv1_lv2_gnt), 64'h0);
        chk("t6_strobe", 64'(bus.data_in_bus_lv1_lv2), 64'h0);
        chk("t6_data", 64'(bus.data_bus_lv1_lv2), 64'h0);
        chk("t6_arr_addr", 64'(bus.lv2_arr_addr), 64'h0);
        chk("t6_owner", 64'(bus.gnt_owner), 64'h0);
        tick();
        bus.lv2_arr_vld = 1'b0;
        chk("t6_first_gnt", 64'(bus.bus_lv1_lv2_gnt), 64'h04);
        chk("t6_no_strobe", 64'(bus.data_in_bus_lv1_lv2), 64'h0);
        chk("t6_no_arr_rd", 64'(bus.lv2_arr_rd), 64'h0);
        bus.bus_lv1_lv2_req = 8'h00;
        tick();
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
